// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - single-outstanding initiator for the ABUS/DBUS/we memory-mapped I/O bus
// Optional feature: define IO_BUS_MASTER_TIMEOUT_EN to abort a request when bus_gnt never arrives.
// Ports:
//   clk, rst (asynchronous, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata : client request, one outstanding
//   rsp_valid/rsp_rdata/rsp_err                    : one-cycle response pulse, data/err held until next response
//   bus_req/bus_gnt                                : ownership handshake with the bus arbiter
//   ABUS, DBUS (tri-state), we                     : shared bus; DBUS driven only in a write transfer cycle
module io_bus_master #(
  parameter int DBITS       = 32,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [DBITS-1:0] req_addr,
  input  logic [DBITS-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DBITS-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [DBITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] DBUS,
  output logic             we
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("io_bus_master: WAIT_STATES or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t           state, state_next;
  logic             lat_we;
  logic [DBITS-1:0] lat_addr;
  logic [DBITS-1:0] lat_wdata;
  logic [3:0]       wait_cnt;
  logic             dbus_en;
  logic             accept;
  logic             xfer_last;
  logic             timed_out;

  // Gated by rst so the client never sees ready while reset is held.
  assign req_ready = rst && (state == IDLE);
  assign accept    = req_valid && req_ready;
  // A write transfers in one cycle; a read holds ABUS for WAIT_STATES extra cycles.
  assign xfer_last = lat_we || (wait_cnt == WAIT_LAST);

`ifdef IO_BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
  logic       err_q;
  // to_cnt counts completed grant-wait cycles, so the last one is TIMEOUT-1.
  assign timed_out = (to_cnt >= TO_LAST);
  assign rsp_err   = err_q;
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign DBUS = dbus_en ? lat_wdata : {DBITS{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    bus_req    = 1'b0;
    ABUS       = '0;
    we         = 1'b0;
    dbus_en    = 1'b0;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt)        state_next = XFER;
        else if (timed_out) state_next = DONE;
      end
      XFER: begin
        bus_req = 1'b1;
        ABUS    = lat_addr;
        we      = lat_we;
        dbus_en = lat_we;
        if (xfer_last) state_next = DONE;
      end
      DONE: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        wait_cnt  <= '0;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
        to_cnt    <= '0;
`endif
      end
`ifdef IO_BUS_MASTER_TIMEOUT_EN
      if (state == REQ && !bus_gnt) begin
        if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
        if (timed_out) begin
          rsp_rdata <= '0;
          err_q     <= 1'b1;
        end
      end
`endif
      if (state == XFER) begin
        if (!xfer_last) begin
          wait_cnt <= wait_cnt + 4'd1;
        end else begin
          rsp_rdata <= lat_we ? '0 : DBUS;
`ifdef IO_BUS_MASTER_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - self-checking bench for io_bus_master with a bus responder model
module tb_io_bus_master;
  localparam int DBITS = 32;
  localparam int WS    = 1;
  localparam int TO    = 15;

  localparam logic [31:0] LEDR_A = 32'hF000_0004;
  localparam logic [31:0] SW_A   = 32'hF000_0014;
  localparam logic [31:0] SW_V   = 32'h0000_0155;
  localparam logic [31:0] IDLE_V = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] ABUS;
  wire  [31:0] DBUS;
  logic        we;

  io_bus_master #(.DBITS(DBITS), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .ABUS(ABUS), .DBUS(DBUS), .we(we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_seed(input int i);
    return (32'h1111_1111 * 32'(i + 1)) ^ 32'h0F0F_0000;
  endfunction

  // Bus responders: LEDR, SW and a 16-word RAM at 0x100; idle pattern elsewhere.
  logic [31:0] ledr;
  logic [31:0] bus_mem [16];
  logic [31:0] rd_val;
  always_comb begin
    if (ABUS == SW_A)              rd_val = SW_V;
    else if (ABUS == LEDR_A)       rd_val = ledr;
    else if (ABUS[31:6] == 26'h4)  rd_val = bus_mem[ABUS[5:2]];
    else                           rd_val = IDLE_V;
  end
  assign DBUS = we ? 32'hzzzz_zzzz : rd_val;

  always @(posedge clk) begin
    if (!rst) begin
      ledr <= '0;
      for (int i = 0; i < 16; i++) bus_mem[i] <= mem_seed(i);
    end else if (we) begin
      if (ABUS == LEDR_A)           ledr <= DBUS;
      else if (ABUS[31:6] == 26'h4) bus_mem[ABUS[5:2]] <= DBUS;
    end
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction; grant given gdel cycles after bus_req is first seen, then withdrawn during XFER.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int gdel,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int xfer_n, output int bad_n, output logic breq_done);
    int acc, bcnt, n;
    bad_n = 0; xfer_n = 0; lat = -1; rd = '0; er = 1'b0; breq_done = 1'b1; bcnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (n < 400) begin
      if (ABUS != 0) begin
        xfer_n++;
        bus_gnt = 1'b0;
        if (ABUS != a) bad_n++;
      end else if (bus_req && xfer_n == 0) begin
        if (bcnt >= gdel) bus_gnt = 1'b1;
        bcnt++;
      end
      if (we) begin
        if (!w || DBUS != d || ABUS != a) bad_n++;
      end else if (DBUS != rd_val) bad_n++;
      if (rsp_valid) begin
        lat = cyc - acc + 1; rd = rsp_rdata; er = rsp_err; breq_done = bus_req;
        break;
      end
      @(negedge clk);
      n++;
    end
    bus_gnt = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          gdel;
    int          lat;
    logic [31:0] rd;
    int          xfer;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] ref_mem [16];

  initial begin
    int          lat, xfer_n, bad_n, nacc, nrsp, nwe, idx, gdel;
    logic [31:0] rd, a, d;
    logic        er, bd, w, drop;
    int          acc_c [2];
    int          rsp_c [2];
    int          we_c  [2];

    tbl[0] = '{1'b1, LEDR_A,       32'h0000_03FF, 0, 3,          32'h0,         1};
    tbl[1] = '{1'b0, SW_A,         32'h0,         0, 3 + WS,     SW_V,          WS + 1};
    tbl[2] = '{1'b1, 32'h108,      32'h1234_5678, 5, 8,          32'h0,         1};
    tbl[3] = '{1'b0, 32'h108,      32'h0,         2, 3 + WS + 2, 32'h1234_5678, WS + 1};
    tbl[4] = '{1'b0, LEDR_A,       32'h0,         1, 3 + WS + 1, 32'h0000_03FF, WS + 1};
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_seed(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err",   32'(rsp_err), 0);
    chk("rst bus_req",   32'(bus_req), 0);
    chk("rst ABUS",      ABUS, 0);
    chk("rst we",        32'(we), 0);
    chk("rst DBUS released", DBUS, IDLE_V);
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst req_ready", 32'(req_ready), 1);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].gdel, lat, rd, er, xfer_n, bad_n, bd);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d rdata", i), rd, tbl[i].rd);
      chk($sformatf("v%0d err", i), 32'(er), 0);
      chk($sformatf("v%0d xfer cycles", i), 32'(xfer_n), 32'(tbl[i].xfer));
      chk($sformatf("v%0d bus errors", i), 32'(bad_n), 0);
      chk($sformatf("v%0d bus_req in DONE", i), 32'(bd), 0);
      if (tbl[i].w && tbl[i].a[31:6] == 26'h4) ref_mem[tbl[i].a[5:2]] = tbl[i].d;
    end
    chk("LEDR value", ledr, 32'h3FF);

    // Grant never arrives (or arrives late without the timeout feature)
`ifdef IO_BUS_MASTER_TIMEOUT_EN
    do_txn(1'b0, 32'h104, 32'h0, 1000, lat, rd, er, xfer_n, bad_n, bd);
    chk("timeout latency", 32'(lat), 32'(1 + TO));
    chk("timeout err", 32'(er), 1);
    chk("timeout rdata", rd, 0);
    chk("timeout xfer cycles", 32'(xfer_n), 0);
`else
    do_txn(1'b0, 32'h104, 32'h0, 40, lat, rd, er, xfer_n, bad_n, bd);
    chk("long wait latency", 32'(lat), 32'(3 + WS + 40));
    chk("long wait err", 32'(er), 0);
    chk("long wait rdata", rd, ref_mem[1]);
    chk("long wait xfer cycles", 32'(xfer_n), 32'(WS + 1));
`endif
    chk("grant wait bus errors", 32'(bad_n), 0);
    chk("grant wait bus_req in DONE", 32'(bd), 0);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom);
      idx = int'($urandom_range(0, 15));
      a = 32'h100 + 32'(idx * 4);
      d = $urandom;
      gdel = int'($urandom_range(0, 3));
      do_txn(w, a, d, gdel, lat, rd, er, xfer_n, bad_n, bd);
      chk($sformatf("r%0d latency", i), 32'(lat), 32'(3 + (w ? 0 : WS) + gdel));
      chk($sformatf("r%0d rdata", i), rd, w ? 32'h0 : ref_mem[idx]);
      chk($sformatf("r%0d err", i), 32'(er), 0);
      chk($sformatf("r%0d xfer cycles", i), 32'(xfer_n), 32'(w ? 1 : WS + 1));
      chk($sformatf("r%0d bus errors", i), 32'(bad_n), 0);
      if (w) ref_mem[idx] = d;
    end

    // Back-to-back writes with req_valid held
    acc_c = '{0, 0}; rsp_c = '{0, 0}; we_c = '{0, 0};
    nacc = 0; nrsp = 0; nwe = 0; drop = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10C; req_wdata = 32'hCAFE_0001;
    for (int k = 0; k < 16; k++) begin
      if (we) begin if (nwe < 2) we_c[nwe] = cyc; nwe++; end
      if (rsp_valid) begin if (nrsp < 2) rsp_c[nrsp] = cyc; nrsp++; end
      if (req_valid && req_ready) begin
        if (nacc < 2) acc_c[nacc] = cyc + 1;
        nacc++;
        if (nacc == 2) drop = 1'b1;
      end
      @(negedge clk);
      if (drop) req_valid = 1'b0;
    end
    bus_gnt = 1'b0;
    chk("b2b accepts", 32'(nacc), 2);
    chk("b2b we pulses", 32'(nwe), 2);
    chk("b2b responses", 32'(nrsp), 2);
    chk("b2b we spacing", 32'(we_c[1] - we_c[0]), 4);
    chk("b2b accept spacing", 32'(acc_c[1] - acc_c[0]), 4);
    chk("b2b accept after rsp", 32'(acc_c[1] - rsp_c[0]), 2);
    chk("b2b memory", bus_mem[3], 32'hCAFE_0001);

    // Reset asserted during a write transfer
    @(negedge clk);
    bus_gnt = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h110; req_wdata = 32'h0000_7777;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !we; k++) @(negedge clk);
    chk("mid-write we seen", 32'(we), 1);
    #1 rst = 1'b0;
    #1;
    chk("async rst we", 32'(we), 0);
    chk("async rst bus_req", 32'(bus_req), 0);
    chk("async rst ABUS", ABUS, 0);
    chk("async rst DBUS released", DBUS, IDLE_V);
    chk("async rst rsp_valid", 32'(rsp_valid), 0);
    chk("async rst req_ready", 32'(req_ready), 0);
    bus_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk("ready after rst release", 32'(req_ready), 1);
      if (rsp_valid) nrsp++;
    end
    chk("no rsp after reset", 32'(nrsp), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
